// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
package lsu_pkg;
  localparam int LSU_AW     = 8;
  localparam int LSU_DW     = 8;
  localparam int LSU_RW     = 2;
  localparam int LSU_TO_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic              is_load;
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] st_data;
    logic [LSU_RW-1:0] dst_reg;
  } lsu_req_t;
endpackage

// File: rtl/lsu_timeout_ctr.sv
// Counts REQ cycles without ack; expired is high in the cycle that reaches TO_CYC.
module lsu_timeout_ctr #(
  parameter int TO_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // The TO_CYC-th ack-less cycle is the last one mem_req is held.
  assign expired = en && (cnt_q == CW'(TO_CYC - 1));
endmodule

// File: rtl/load_store_unit.sv
// Byte load/store unit driving the data-memory handshake and register write-back.
// Optional REQ timeout is built when LSU_TIMEOUT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW     = LSU_AW,
  parameter int DW     = LSU_DW,
  parameter int RW     = LSU_RW,
  parameter int TO_CYC = LSU_TO_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_load,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] st_data,
  input  logic [RW-1:0] dst_reg,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          wb_en,
  output logic [RW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          busy,
  output logic          done,
  output logic          err
);
  lsu_state_t    state_q, state_d;
  lsu_req_t      req_q, req_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          accept;
  logic          to_expired;

  // WB always retires in its single cycle, so a start there is taken as if IDLE;
  // this lets the core issue in the done cycle of a load as well as a store.
  assign accept = start && ((state_q == IDLE) || (state_q == WB));

`ifdef LSU_TIMEOUT_EN
  lsu_timeout_ctr #(.TO_CYC(TO_CYC)) u_to (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      ((state_q == REQ) && !mem_ack),
    .expired (to_expired)
  );
`else
  // Never true for a valid TO_CYC: REQ waits for ack indefinitely.
  assign to_expired = (TO_CYC < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (mem_ack)         state_d = req_q.is_load ? WB : IDLE;
        else if (to_expired) state_d = IDLE;
      end
      WB:      state_d = start ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    if (accept) begin
      req_d.is_load = is_load;
      req_d.addr    = addr;
      req_d.st_data = st_data;
      req_d.dst_reg = dst_reg;
    end
    if ((state_q == REQ) && mem_ack && req_q.is_load) rdata_d = mem_rdata;
    done_d = (state_q == REQ) && ((mem_ack && !req_q.is_load) || (!mem_ack && to_expired));
    // An ack outside REQ carries no transaction; a timeout also reports here.
    err_d  = (mem_ack && (state_q != REQ)) || ((state_q == REQ) && !mem_ack && to_expired);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = (state_q == REQ) && !req_q.is_load;
    mem_addr  = req_q.addr;
    mem_wdata = req_q.st_data;
    wb_en     = (state_q == WB);
    wb_addr   = (state_q == WB) ? req_q.dst_reg : '0;
    wb_data   = (state_q == WB) ? rdata_q : '0;
    busy      = (state_q != IDLE);
    done      = done_q || (state_q == WB);
    err       = err_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against a byte-memory model.
module tb_load_store_unit;
  localparam int AW = 8, DW = 8, RW = 2, TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, is_load, mem_ack;
  logic [AW-1:0] addr;
  logic [DW-1:0] st_data, mem_rdata;
  logic [RW-1:0] dst_reg;
  logic          mem_req, mem_we, wb_en, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, wb_data;
  logic [RW-1:0] wb_addr;

  int vecs = 0;
  int errs = 0;
  // mem: storage written only from the DUT's bus; shadow: what the program intends.
  logic [7:0] mem[256];
  logic [7:0] shadow[256];

  always #5 clk = ~clk;

  load_store_unit #(.AW(AW), .DW(DW), .RW(RW), .TO_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .addr(addr),
    .st_data(st_data), .dst_reg(dst_reg), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .err(err)
  );

  // One transaction; ack on REQ cycle n. Entered and left at a negedge
  // (leaves in the done cycle so the caller may issue back-to-back).
  task automatic do_txn(input logic ld, input logic [7:0] a, input logic [7:0] d,
                        input logic [1:0] r, input int n);
    logic [7:0] exp_rd;
    start = 1'b1; is_load = ld; addr = a; st_data = d; dst_reg = r;
    @(posedge clk); #1;
    start = 1'b0; is_load = 1'($urandom); addr = 8'($urandom);
    st_data = 8'($urandom); dst_reg = 2'($urandom);
    for (int c = 1; c <= n; c++) begin
      mem_ack   = (c == n);
      mem_rdata = (c == n && ld) ? mem[mem_addr] : 8'($urandom);
      @(negedge clk);
      vecs++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, done, wb_en, err} !==
          {1'b1, ~ld, a, d, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL req_cyc%0d: got req=%b we=%b addr=%h wd=%h busy=%b done=%b wb=%b err=%b want we=%b addr=%h wd=%h",
                 c, mem_req, mem_we, mem_addr, mem_wdata, busy, done, wb_en, err, ~ld, a, d);
      end
      if (c == n && !ld && mem_req && mem_we) mem[mem_addr] = mem_wdata;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    exp_rd = shadow[a];
    if (!ld) shadow[a] = d;
    @(negedge clk);
    vecs++;
    if ({done, wb_en, wb_addr, wb_data, mem_req, busy, err} !==
        {1'b1, ld, (ld ? r : 2'b00), (ld ? exp_rd : 8'h00), 1'b0, ld, 1'b0}) begin
      errs++;
      $display("FAIL done_cyc: got done=%b wb=%b wa=%0d wd=%h req=%b busy=%b err=%b want wb=%b wa=%0d wd=%h",
               done, wb_en, wb_addr, wb_data, mem_req, busy, err, ld, (ld ? r : 2'b00), (ld ? exp_rd : 8'h00));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    @(negedge clk);
    vecs++;
    if ({busy, mem_req, done, wb_en, err} !== 5'b0) begin
      errs++;
      $display("FAIL idle: got busy=%b req=%b done=%b wb=%b err=%b want all 0",
               busy, mem_req, done, wb_en, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_load = 1'b0; addr = '0; st_data = '0;
    dst_reg = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, busy, done, err} !== '0) begin
      errs++;
      $display("FAIL reset_vals: got req=%b we=%b a=%h wd=%h wb=%b wa=%0d wdat=%h busy=%b done=%b err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_addr, wb_data, busy, done, err);
    end
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_load_first_ack();
    mem[8'h10] = 8'hA5; shadow[8'h10] = 8'hA5;
    do_txn(1'b1, 8'h10, 8'h00, 2'b10, 1);
    idle_cycle();
  endtask

  task automatic test_store_3cyc();
    do_txn(1'b0, 8'h20, 8'h3C, 2'b01, 3);
    vecs++;
    if (mem[8'h20] !== 8'h3C) begin
      errs++;
      $display("FAIL store_written: got mem[20]=%h want 3c", mem[8'h20]);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 8'h05, 8'h77, 2'b11, 2);
    do_txn(1'b0, 8'h05, 8'hC3, 2'b00, 1);
    do_txn(1'b1, 8'h05, 8'h11, 2'b01, 1);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; is_load = 1'b1; addr = 8'h40; dst_reg = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    vecs++;
    if (mem_req !== 1'b1) begin
      errs++;
      $display("FAIL rst_mid_pre: got req=%b want 1", mem_req);
    end
    #1 reset = 1'b1;
    #1;
    vecs++;
    if ({mem_req, busy} !== 2'b00) begin
      errs++;
      $display("FAIL rst_mid_async: got req=%b busy=%b want 0 0", mem_req, busy);
    end
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    vecs++;
    if ({err, done, wb_en, mem_req, busy} !== 5'b10000) begin
      errs++;
      $display("FAIL rst_late_ack: got err=%b done=%b wb=%b req=%b busy=%b want 1 0 0 0 0",
               err, done, wb_en, mem_req, busy);
    end
    idle_cycle();
  endtask

  task automatic test_spurious_ack();
    logic [7:0] a_before;
    a_before = mem_addr;
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    vecs++;
    if ({err, busy, mem_req, done, wb_en, wb_data, mem_addr} !== {5'b10000, 8'h00, a_before}) begin
      errs++;
      $display("FAIL spurious: got err=%b busy=%b req=%b done=%b wb=%b wd=%h a=%h want err=1 rest 0 a=%h",
               err, busy, mem_req, done, wb_en, wb_data, mem_addr, a_before);
    end
    idle_cycle();
  endtask

  task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
    start = 1'b1; is_load = 1'b1; addr = 8'h33; dst_reg = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      vecs++;
      if ({mem_req, err, done} !== 3'b100) begin
        errs++;
        $display("FAIL to_hold%0d: got req=%b err=%b done=%b want 1 0 0", c, mem_req, err, done);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vecs++;
    if ({mem_req, err, done, wb_en, busy} !== 5'b01100) begin
      errs++;
      $display("FAIL to_fire: got req=%b err=%b done=%b wb=%b busy=%b want 0 1 1 0 0",
               mem_req, err, done, wb_en, busy);
    end
    idle_cycle();
    do_txn(1'b1, 8'h33, 8'h00, 2'b10, TO);
    idle_cycle();
`else
    do_txn(1'b1, 8'h33, 8'h00, 2'b10, 3 * TO);
    idle_cycle();
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
             2'($urandom), $urandom_range(1, TO));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end
    test_reset();
    test_load_first_ack();
    test_store_3cyc();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
